// File: rtl/arcadia_hit_pkg.sv
// Shared types for the core region hit collector.
// Record layout, address widths and scan FSM states.
package arcadia_hit_pkg;

  localparam int N_PRS             = 16;
  localparam int PR_DATA_BITS      = 16;
  localparam int CORE_ADDRESS_BITS = 4;
  localparam int PR_ADDR_BITS      = $clog2(N_PRS);

  typedef struct packed {
    logic [CORE_ADDRESS_BITS-1:0] core_address;
    logic [PR_ADDR_BITS-1:0]      pr_address;
    logic [PR_DATA_BITS-1:0]      hitmap;
  } hit_record_t;

  typedef enum logic {
    IDLE,
    SCAN
  } collector_state_t;

endpackage

// File: rtl/core_region_hit_collector_fifo.sv
// Synchronous record FIFO; a push and a pop at full is legal.
// Pointers wrap naturally, count carries one extra bit.
module hit_record_fifo
  import arcadia_hit_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  hit_record_t   push_data,
  input  logic          pop,
  output hit_record_t   pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  hit_record_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/core_region_hit_collector.sv
// Snapshots one core's region hitmaps and streams one record
// per non-empty region, lowest PR first, over valid/ready.
module core_region_hit_collector
  import arcadia_hit_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CORE_ADDRESS_BITS-1:0]         core_address,
  input  logic [N_PRS-1:0][PR_DATA_BITS-1:0]   region_hitmap,
  input  logic                                 capture,
  output logic                                 busy,
  output logic                                 capture_drop,
  output logic                                 scan_done,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [CORE_ADDRESS_BITS-1:0]         out_core_address,
  output logic [PR_ADDR_BITS-1:0]              out_pr_address,
  output logic [PR_DATA_BITS-1:0]              out_hitmap,
  output logic [15:0]                          drop_count,
  output logic [15:0]                          record_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  collector_state_t state_q, state_d;
  logic [N_PRS-1:0][PR_DATA_BITS-1:0] snap_q;
  logic [CORE_ADDRESS_BITS-1:0] core_q;
  logic [N_PRS-1:0] pend_q, pend_d;
  logic [N_PRS-1:0] cap_mask;
  logic [N_PRS-1:0] clr_mask;
  logic [PR_ADDR_BITS-1:0] sel;
  logic push, pop, last;
  logic fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  logic done_d, drop_d;
  hit_record_t push_rec, head;

  always_comb begin
    for (int i = 0; i < N_PRS; i++) begin
      cap_mask[i] = |region_hitmap[i];
    end
  end

  // Lowest set pending bit wins.
  always_comb begin
    sel = '0;
    for (int i = N_PRS-1; i >= 0; i--) begin
      if (pend_q[i]) sel = PR_ADDR_BITS'(i);
    end
  end

  assign clr_mask = N_PRS'(1) << sel;
  assign last     = ((pend_q & ~clr_mask) == '0);
  assign pop      = ~fifo_empty & out_ready;
  assign push     = (state_q == SCAN) & (~fifo_full | pop);

  assign push_rec.core_address = core_q;
  assign push_rec.pr_address   = sel;
  assign push_rec.hitmap       = snap_q[sel];

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          pend_d = cap_mask;
          if (|cap_mask) state_d = SCAN;
          else           done_d  = 1'b1;
        end
      end
      SCAN: begin
        drop_d = capture;
        if (push) begin
          pend_d = pend_q & ~clr_mask;
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      snap_q       <= '0;
      core_q       <= '0;
      scan_done    <= 1'b0;
      capture_drop <= 1'b0;
      drop_count   <= '0;
      record_count <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      scan_done    <= done_d;
      capture_drop <= drop_d;
      if (state_q == IDLE && capture) begin
        snap_q <= region_hitmap;
        core_q <= core_address;
      end
      if (drop_d && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (pop) record_count <= record_count + 16'd1;
    end
  end

  hit_record_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign busy             = (state_q == SCAN);
  assign out_valid        = ~fifo_empty;
  assign out_core_address = out_valid ? head.core_address : '0;
  assign out_pr_address   = out_valid ? head.pr_address   : '0;
  assign out_hitmap       = out_valid ? head.hitmap       : '0;

endmodule

// File: doc/core_region_hit_collector.md
Name: core_region_hit_collector

Overview:
Consumes the per-core region hitmap bus that feeds the region probes.
- On a capture strobe, snapshots all pixel-region (PR) hitmaps of one core.
- Scans the snapshot lowest-PR-first and queues one record {core_address, pr_address, hitmap} per non-empty region into a FIFO.
- Streams the records out over valid/ready to the hit monitor/scoreboard path.

Parameters:
- N_PRS, 16, pixel regions per core (bound to `ARCADIA_CORE_PRS)
- PR_DATA_BITS, 16, hitmap bits per region (bound to `ARCADIA_PR_DATA_BITS)
- CORE_ADDRESS_BITS, 4, core address width (bound to `ARCADIA_CORE_ADDRESS_BITS)
- FIFO_DEPTH, 8, record FIFO entries, power of two, >=2

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- core_address  input  CORE_ADDRESS_BITS  address of the observed core, latched at capture
- region_hitmap  input  N_PRS x PR_DATA_BITS  packed per-region hitmaps; index = PR address
- capture  input  1  one-cycle strobe: snapshot region_hitmap
- busy  output  1  snapshot scan in progress
- capture_drop  output  1  one-cycle pulse: capture ignored because busy
- scan_done  output  1  one-cycle pulse: last pending region pushed
- out_valid  output  1  record available at FIFO head
- out_ready  input  1  consumer accepts record
- out_core_address  output  CORE_ADDRESS_BITS  record core address
- out_pr_address  output  $clog2(N_PRS)  record PR index
- out_hitmap  output  PR_DATA_BITS  record hitmap, never all-zero
- drop_count  output  16  saturating count of dropped captures
- record_count  output  16  wrapping count of records accepted by the consumer

Behaviour:
- Reset: all outputs 0. FSM=IDLE, FIFO empty, pending mask 0, counters 0. rst mid-scan discards the snapshot and all queued records; no scan_done.
- FSM states IDLE, SCAN.
- IDLE & capture:
  - Latch region_hitmap and core_address.
  - pending[i] = |region_hitmap[i].
  - If any pending bit is set, go to SCAN (busy=1 from the next cycle). Otherwise stay IDLE, pulse scan_done next cycle, push nothing.
- SCAN, each cycle:
  - Select the lowest set pending index p.
  - If a push is allowed, write {latched core_address, p, snapshot[p]}, clear pending[p].
  - When the cleared bit was the last: go to IDLE and pulse scan_done in the same cycle busy drops.
- Push allowed when count<FIFO_DEPTH, or when count==FIFO_DEPTH and out_valid&out_ready this cycle (simultaneous push/pop at full is legal).
- FIFO full with no pop: scan stalls, pending unchanged, no loss.
- capture while busy: ignored. Snapshot and pending unchanged. capture_drop pulses next cycle. drop_count +1, saturating at 16'hFFFF.
- Latency: capture high in cycle 0 -> SCAN in cycle 1 -> first push at the end of cycle 1 -> out_valid=1 in cycle 2. With out_ready held high, one record per cycle.
- Output handshake:
  - out_* stable while out_valid&!out_ready.
  - Transfer on out_valid&out_ready; record_count +1 (wraps).
  - out_valid deasserts only after the last record pops.
- Record order: ascending PR within a snapshot; snapshots never interleave.
- FIFO pointers: log2(FIFO_DEPTH) bits, wrap naturally. count is log2(FIFO_DEPTH)+1 bits.
- region_hitmap changes after capture have no effect on the current scan.

Decomposition:
- arcadia_hit_pkg: typedef hit_record_t {core_address, pr_address, hitmap}; localparam PR_ADDR_BITS=$clog2(N_PRS); FSM enum collector_state_t {IDLE, SCAN}.
- Sub-module hit_record_fifo: sync FIFO of hit_record_t, push/pop/full/empty/count, same clk/rst.
- Priority encoder for pending stays inline.

Test Plan:
- rst, then capture with PR3=16'h0001, PR7=16'h8000, others 0, core_address=4'h5, out_ready=1 -> records (5,3,0001) in cycle 2, (5,7,8000) in cycle 3; scan_done with busy falling; record_count=2.
- capture with all-zero hitmap -> no records, busy stays 0, scan_done pulses once.
- All 16 PRs = 16'hFFFF, FIFO_DEPTH=8, out_ready=0 -> 8 records queued, scan stalls with busy=1. Raise out_ready -> 16 records in PR order 0..15; no drops.
- Second capture 2 cycles after first (busy) -> capture_drop pulse, drop_count=1; output holds only first-snapshot records.
- out_ready toggled 1/0 every cycle during an 8-region scan -> out_* stable when not accepted, exactly 8 transfers, no duplicates.
- rst asserted mid-scan with 4 records queued -> next cycle out_valid=0, busy=0, counters 0, no scan_done; a fresh capture then works normally.
